// File: rtl/paddle_input_filter.sv
// Paddle position filter. It alternates the ADC mux between the two pots and averages a burst
// of samples per channel. Each average is scaled to a paddle top Y, with hysteresis applied.
module paddle_input_filter #(
    parameter int unsigned SETTLE_CYCLES = 250,
    parameter int unsigned SAMPLE_GAP    = 16,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned Y_MAX         = 480,
    parameter int unsigned PAD_SMALL     = 40,
    parameter int unsigned PAD_LARGE     = 80,
    parameter int unsigned HYST          = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_adc,
    input  logic       i_bat_size,
    output logic       o_sel,
    output logic [9:0] o_p1_y,
    output logic [9:0] o_p2_y,
    output logic       o_y_upd
);

    localparam int unsigned ACC_W   = 9 + AVG_LOG2;
    localparam int unsigned NSAMP   = 1 << AVG_LOG2;
    localparam int unsigned NS_W    = AVG_LOG2 + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_GAP) ? SETTLE_CYCLES : SAMPLE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [9:0]  Y_RST   = 10'((Y_MAX - PAD_LARGE) / 2);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SAMPLE,
        ST_CALC_AVG,
        ST_CALC_SCALE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic [NS_W-1:0]    r_nsamp;
    logic [ACC_W-1:0]   r_acc;
    logic [8:0]         r_avg;
    logic [9:0]         r_h;
    logic [9:0]         r_p1_y;
    logic [9:0]         r_p2_y;
    logic               r_y_upd;

    logic               w_settle_done;
    logic               w_capture;
    logic               w_last_samp;
    logic [9:0]         w_span;
    logic [18:0]        w_prod;
    logic [9:0]         w_cand;
    logic [9:0]         w_cur;
    logic signed [10:0] w_diff;
    logic [10:0]        w_absdiff;
    logic               w_take;

    assign w_settle_done = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_capture     = (r_cnt == '0);
    assign w_last_samp   = (r_nsamp == NS_W'(NSAMP - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SETTLE:     if (w_settle_done) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE:     if (w_capture && w_last_samp) w_state_nxt = ST_CALC_AVG;
            ST_CALC_AVG:   w_state_nxt = ST_CALC_SCALE;
            ST_CALC_SCALE: w_state_nxt = ST_SETTLE;
            default:       w_state_nxt = ST_SETTLE;
        endcase
    end

    // Scaling and hysteresis for the channel currently being finished
    always_comb begin
        w_span    = 10'(Y_MAX) - r_h;
        w_prod    = 19'(r_avg) * 19'(w_span);
        w_cand    = 10'(w_prod >> 9);
        w_cur     = r_ch ? r_p2_y : r_p1_y;
        w_diff    = $signed({1'b0, w_cand}) - $signed({1'b0, w_cur});
        w_absdiff = w_diff[10] ? -w_diff : w_diff;
        // A value left beyond the screen by a bat-size increase bypasses hysteresis
        w_take    = (w_cur > w_span) || (w_absdiff > 11'(HYST));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ch    <= 1'b0;
            r_cnt   <= '0;
            r_nsamp <= '0;
            r_acc   <= '0;
            r_avg   <= '0;
            r_h     <= '0;
            r_p1_y  <= Y_RST;
            r_p2_y  <= Y_RST;
            r_y_upd <= 1'b0;
        end else begin
            r_y_upd <= 1'b0;
            case (r_state)
                ST_SETTLE: begin
                    r_acc   <= '0;
                    r_nsamp <= '0;
                    r_cnt   <= w_settle_done ? '0 : r_cnt + CNT_W'(1);
                end
                ST_SAMPLE: begin
                    if (w_capture) begin
                        r_acc   <= r_acc + ACC_W'(i_adc);
                        r_nsamp <= r_nsamp + NS_W'(1);
                    end
                    r_cnt <= (r_cnt == CNT_W'(SAMPLE_GAP - 1)) ? '0 : r_cnt + CNT_W'(1);
                end
                ST_CALC_AVG: begin
                    r_cnt <= '0;
                    r_avg <= 9'(r_acc >> AVG_LOG2);
                    r_h   <= i_bat_size ? 10'(PAD_LARGE) : 10'(PAD_SMALL);
                end
                ST_CALC_SCALE: begin
                    r_cnt <= '0;
                    if (w_take) begin
                        if (r_ch) r_p2_y <= w_cand;
                        else      r_p1_y <= w_cand;
                    end
                    r_y_upd <= w_take && (w_cand != w_cur);
                    r_ch    <= ~r_ch;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_sel   = r_ch;
    assign o_p1_y  = r_p1_y;
    assign o_p2_y  = r_p2_y;
    assign o_y_upd = r_y_upd;

endmodule
